// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/debug loader, the data memory and dmem_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int CNT_WIDTH     = 16
);
  logic                     c_req;
  logic                     c_we;
  logic [ADDRESS_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0]    c_wdata;
  logic                     c_gnt;
  logic [DATA_WIDTH-1:0]    c_rdata;
  logic                     core_stall;

  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic                     d_gnt;
  logic [DATA_WIDTH-1:0]    d_rdata;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic [CNT_WIDTH-1:0]     force_cnt;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output c_gnt, c_rdata, core_stall,
    output d_gnt, d_rdata,
    output mem_addr, mem_wdata, mem_we,
    output force_cnt
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  c_gnt, c_rdata, core_stall,
    input  d_gnt, d_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  force_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between core (fixed priority) and DMA; zero-latency grant and read.
// Backpressure: core_stall when the core is denied; DMA is denied at most MAX_WAIT cycles before a forced grant.
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MAX_WAIT      = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t                   state;
  logic [WW-1:0]            wait_cnt;
  logic [CNT_WIDTH-1:0]     force_cnt;

  logic                     c_gnt;
  logic                     d_gnt;
  logic [ADDRESS_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0]    wdata_mux;
  logic                     we_mux;

  // Grants are blocked while reset is high so no write can slip through mid-reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (state == FORCE && bus.d_req) begin
        d_gnt = 1'b1;
      end else if (bus.c_req) begin
        c_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (c_gnt) begin
      addr_mux  = bus.c_addr;
      wdata_mux = bus.c_wdata;
      we_mux    = bus.c_we;
    end else if (d_gnt) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      we_mux    = bus.d_we;
    end
  end

  assign bus.c_gnt      = c_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.core_stall = bus.c_req & ~c_gnt;
  assign bus.c_rdata    = c_gnt ? bus.mem_rdata : '0;
  assign bus.d_rdata    = d_gnt ? bus.mem_rdata : '0;
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.mem_we     = we_mux;
  assign bus.force_cnt  = force_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= NORMAL;
      wait_cnt  <= '0;
      force_cnt <= '0;
    end else begin
      if (bus.d_req && !d_gnt) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        NORMAL: begin
          if (bus.d_req && !d_gnt && wait_cnt == WAIT_LAST) begin
            state <= FORCE;
          end
        end
        FORCE: begin
          // Only a forced cycle that actually served the DMA is counted.
          state <= NORMAL;
          if (d_gnt && force_cnt != {CNT_WIDTH{1'b1}}) begin
            force_cnt <= force_cnt + 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle expected bus snapshots are queued with the stimulus and popped at negedge.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .CNT_WIDTH(16)) bus ();

  dmem_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MAX_WAIT(4), .CNT_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

  // {c_gnt, d_gnt, mem_we, core_stall, mem_addr, mem_wdata, c_rdata, d_rdata}
  typedef logic [131:0] vec_t;
  vec_t exp_q[$];
  vec_t exp_v;
  vec_t got;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic cg, input logic dg, input logic we, input logic st,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] cr, input logic [31:0] dr);
    return {cg, dg, we, st, a, wd, cr, dr};
  endfunction

  function automatic vec_t obs();
    return {bus.c_gnt, bus.d_gnt, bus.mem_we, bus.core_stall,
            bus.mem_addr, bus.mem_wdata, bus.c_rdata, bus.d_rdata};
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'd7, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'd8, 32'h0BAD_0008);
    reset = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0));
    @(negedge clk);
    exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h want %h", got, exp_v); end
    n_cmp++;
    if (bus.force_cnt !== 16'd0) begin n_err++; $display("FAIL reset_force_cnt: got %0d want 0", bus.force_cnt); end
    @(posedge clk); #1;
    reset = 1'b0; bus.c_we = 1'b0; bus.d_we = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'h0BAD_0BAD, ref_mem[7], 32'd0));
    @(negedge clk);
    exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", got, exp_v); end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[7] !== ref_mem[7]) begin n_err++; $display("FAIL reset_no_write: got %h want %h", mem[7], ref_mem[7]); end
  endtask

  task automatic test_core_rw();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF, ref_mem[5], 32'd0));
      end else begin
        drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'd0));
      end
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL core_rw cyc %0d: got %h want %h", i, got, exp_v); end
      @(posedge clk); #1;
      if (i == 0) ref_mem[5] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic test_contention();
    logic dg;
    apply_reset();
    drive(1'b1, 1'b0, 32'd1, 32'h11, 1'b1, 1'b0, 32'd2, 32'h22);
    for (int i = 0; i < 10; i++) begin
      dg = (i % 5 == 4);
      exp_q.push_back(mk(!dg, dg, 1'b0, dg, dg ? 32'd2 : 32'd1, dg ? 32'h22 : 32'h11,
                         dg ? 32'd0 : ref_mem[1], dg ? ref_mem[2] : 32'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL contention cyc %0d: got %h want %h", i, got, exp_v); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.force_cnt !== 16'd2) begin n_err++; $display("FAIL contention_force_cnt: got %0d want 2", bus.force_cnt); end
  endtask

  task automatic test_force_drop();
    logic dg;
    apply_reset();
    drive(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 32'd6, 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.d_req = (i != 4);
      dg = (i == 9);
      if (i == 5) begin
        n_cmp++;
        if (bus.force_cnt !== 16'd0) begin n_err++; $display("FAIL drop_force_cnt: got %0d want 0", bus.force_cnt); end
      end
      exp_q.push_back(mk(!dg, dg, 1'b0, dg, dg ? 32'd6 : 32'd4, 32'd0,
                         dg ? 32'd0 : ref_mem[4], dg ? ref_mem[6] : 32'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL force_drop cyc %0d: got %h want %h", i, got, exp_v); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.force_cnt !== 16'd1) begin n_err++; $display("FAIL drop_force_cnt_end: got %0d want 1", bus.force_cnt); end
  endtask

  task automatic test_dma_writes();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'(i), 32'hCAFE_0000 + 32'(i));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'(i), 32'hCAFE_0000 + 32'(i), 32'd0, ref_mem[i]));
      end else begin
        drive(1'b1, 1'b0, 32'd6, 32'd0, 1'b1, 1'b0, 32'd3, 32'd0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd0, ref_mem[6], 32'd0));
      end
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL dma_writes cyc %0d: got %h want %h", i, got, exp_v); end
      @(posedge clk); #1;
      if (i < 4) ref_mem[i] = 32'hCAFE_0000 + 32'(i);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    n_cmp++;
    if (bus.force_cnt !== 16'd0) begin n_err++; $display("FAIL dma_force_cnt: got %0d want 0", bus.force_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[i] !== ref_mem[i]) begin n_err++; $display("FAIL dma_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_in_force();
    logic dg;
    apply_reset();
    drive(1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b1, 32'd9, 32'h9999_9999);
    for (int i = 0; i < 5; i++) begin
      dg = (i == 4);
      exp_q.push_back(mk(!dg, dg, dg, dg, dg ? 32'd9 : 32'd3, dg ? 32'h9999_9999 : 32'd0,
                         dg ? 32'd0 : ref_mem[3], dg ? ref_mem[9] : 32'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_force cyc %0d: got %h want %h", i, got, exp_v); end
      if (i < 4) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0));
    #1;
    exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL rst_force_hold: got %h want %h", got, exp_v); end
    @(posedge clk); #1;
    reset = 1'b0; bus.d_we = 1'b0;
    n_cmp++;
    if (bus.force_cnt !== 16'd0) begin n_err++; $display("FAIL rst_force_cnt: got %0d want 0", bus.force_cnt); end
    for (int i = 0; i < 5; i++) begin
      dg = (i == 4);
      exp_q.push_back(mk(!dg, dg, 1'b0, dg, dg ? 32'd9 : 32'd3, dg ? 32'h9999_9999 : 32'd0,
                         dg ? 32'd0 : ref_mem[3], dg ? ref_mem[9] : 32'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front(); got = obs(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_force_after cyc %0d: got %h want %h", i, got, exp_v); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (mem[9] !== ref_mem[9]) begin n_err++; $display("FAIL rst_force_mem9: got %h want %h", mem[9], ref_mem[9]); end
    n_cmp++;
    if (bus.force_cnt !== 16'd1) begin n_err++; $display("FAIL rst_force_cnt_end: got %0d want 1", bus.force_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    test_reset();
    test_core_rw();
    test_contention();
    test_force_drop();
    test_dma_writes();
    test_reset_in_force();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
